// File: rtl/contador_distancia_bcd.sv
// Echo-pulse width to D-digit BCD distance (cm or inch), saturating at all-9s.
// Optional half-up rounding stage enabled by CONTADOR_DISTANCIA_ARREDONDA_EN.
module contador_distancia_bcd #(
  parameter int R_CM  = 2941,
  parameter int R_POL = 7462,
  parameter int N     = 13,
  parameter int D     = 3
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           pulso,
  input  logic           unidade,
  output logic [4*D-1:0] digitos,
  output logic           fim,
  output logic           pronto,
  output logic           medindo
);

  localparam logic [4*D-1:0] ALL9 = {D{4'h9}};
  localparam logic [4*D-1:0] ONE  = (4*D)'(1);

  typedef enum logic [2:0] {
    ARMA,
    ESPERA,
    CONTA,
`ifdef CONTADOR_DISTANCIA_ARREDONDA_EN
    ARREDONDA,
`endif
    FINAL
  } state_t;

  state_t         r_state;
  logic [N-1:0]   r_ticks;
  logic [4*D-1:0] r_digitos;
  logic           r_fim;
  logic           r_pronto;
  logic           r_medindo;
  logic           r_unit;

  logic [N:0]     w_rsel;
  logic [N:0]     w_rsel_start;
  logic           w_wrap;
  logic           w_start_wrap;
  logic [4*D-1:0] w_inc;

  // Saturating BCD +1: all-9s stays put, otherwise ripple carry through digits.
  function automatic logic [4*D-1:0] bcd_inc(input logic [4*D-1:0] v);
    logic [4*D-1:0] r;
    logic           c;
    r = v;
    c = 1'b1;
    if (v != ALL9) begin
      for (int unsigned k = 0; k < D; k++) begin
        if (c) begin
          if (v[4*k +: 4] == 4'd9) begin
            r[4*k +: 4] = 4'd0;
          end else begin
            r[4*k +: 4] = v[4*k +: 4] + 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    w_rsel       = r_unit  ? (N+1)'(R_POL) : (N+1)'(R_CM);
    w_rsel_start = unidade ? (N+1)'(R_POL) : (N+1)'(R_CM);
    w_wrap       = ({1'b0, r_ticks} == (w_rsel - (N+1)'(1)));
    w_start_wrap = (w_rsel_start == (N+1)'(1));
    w_inc        = bcd_inc(r_digitos);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ARMA;
      r_ticks   <= '0;
      r_digitos <= '0;
      r_fim     <= 1'b0;
      r_pronto  <= 1'b0;
      r_medindo <= 1'b0;
      r_unit    <= 1'b0;
    end else begin
      r_pronto <= 1'b0;
      unique case (r_state)
        ARMA: begin
          if (!pulso) r_state <= ESPERA;
        end
        ESPERA: begin
          if (pulso) begin
            // The starting edge already counts as the first high tick.
            r_unit    <= unidade;
            r_fim     <= 1'b0;
            r_medindo <= 1'b1;
            r_state   <= CONTA;
            if (w_start_wrap) begin
              r_ticks   <= '0;
              r_digitos <= ONE;
              r_fim     <= (ONE == ALL9);
            end else begin
              r_ticks   <= N'(1);
              r_digitos <= '0;
            end
          end
        end
        CONTA: begin
          if (pulso) begin
            if (w_wrap) begin
              r_ticks   <= '0;
              r_digitos <= w_inc;
              r_fim     <= (w_inc == ALL9);
            end else begin
              r_ticks <= r_ticks + N'(1);
            end
          end else begin
            r_medindo <= 1'b0;
`ifdef CONTADOR_DISTANCIA_ARREDONDA_EN
            r_state   <= ARREDONDA;
`else
            r_state   <= FINAL;
            r_pronto  <= 1'b1;
`endif
          end
        end
`ifdef CONTADOR_DISTANCIA_ARREDONDA_EN
        ARREDONDA: begin
          if ({r_ticks, 1'b0} >= w_rsel) begin
            r_digitos <= w_inc;
            r_fim     <= (w_inc == ALL9);
          end
          r_state  <= FINAL;
          r_pronto <= 1'b1;
        end
`endif
        FINAL: begin
          r_state <= ESPERA;
        end
        default: r_state <= ARMA;
      endcase
    end
  end

  assign digitos = r_digitos;
  assign fim     = r_fim;
  assign pronto  = r_pronto;
  assign medindo = r_medindo;

endmodule
